// File: rtl/rf_pkg.sv
// Shared constants, address helper and request types for the integer register file.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    // Smallest width able to index 'value' entries (0 for a single entry).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    localparam int AW_DEF = clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] rf_addr_t;

    typedef struct packed {
        rf_addr_t addr;
        logic     busy;
    } rd_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy bits with flush > issue > writeback priority
// and a registered count of busy registers.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS   = NREGS_DEF,
    parameter int R0_ZERO = 1,
    localparam int AW     = clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    input  logic             rf_en,
    input  logic [AW-1:0]    rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy_nxt;
    logic             inc;
    logic             dec;

    // A set of the same register as a clear wins, so the newest producer keeps it busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_en) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (R0_ZERO != 0) begin
            set_vec[0] = 1'b0;
        end
        if (rf_en) begin
            clr_vec[rd] = 1'b1;
        end
        busy_nxt = (busy & ~clr_vec) | set_vec;
        inc      = |(set_vec & ~busy);
        dec      = |(clr_vec & busy & ~set_vec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else if (flush) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, write-first bypass and
// an integrated busy scoreboard. Define RF_PARITY_EN to add per-register even parity.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NRD     = NRD_DEF,
    parameter int R0_ZERO = 1,
    localparam int AW     = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                rf_en,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     write_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
`ifdef RF_PARITY_EN
    ,
    output logic [NRD-1:0]      parity_err
`endif
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic             wr_ok;

    assign wr_ok = rf_en && !((R0_ZERO != 0) && (rd == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[rd] <= write_data;
        end
    end

`ifdef RF_PARITY_EN
    logic [NREGS-1:0] mem_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_par <= '0;
        end else if (wr_ok) begin
            mem_par[rd] <= ^write_data;
        end
    end
`endif

    rf_scoreboard #(
        .NREGS   (NREGS),
        .R0_ZERO (R0_ZERO)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .rf_en    (rf_en),
        .rd       (rd),
        .flush    (flush),
        .busy     (busy_vec),
        .busy_cnt (busy_cnt)
    );

    // A port reading the register being written sees the new value and is no longer busy.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] rs;
        logic          is_r0;
        logic          byp;

        assign rs    = rs_addr[k*AW +: AW];
        assign is_r0 = (R0_ZERO != 0) && (rs == '0);
        assign byp   = rf_en && (rd == rs);

        assign rd_data[k*XLEN +: XLEN] = is_r0 ? '0 : (byp ? write_data : mem[rs]);
        assign rs_busy[k]              = !is_r0 && !byp && busy_vec[rs];
`ifdef RF_PARITY_EN
        assign parity_err[k] = !is_r0 && !byp && (mem_par[rs] ^ (^mem[rs]));
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reference model plus an expected-value queue.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rs_busy;
    logic                rf_en;
    logic [AW-1:0]       rd;
    logic [XLEN-1:0]     write_data;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic [AW:0]         busy_cnt;
`ifdef RF_PARITY_EN
    logic [NRD-1:0]      parity_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0]  m_mem [NREGS];
    logic [NREGS-1:0] m_busy;
    int               m_cnt;
    logic [XLEN-1:0]  exp_q [$];
    logic [XLEN-1:0]  e;

    regfile_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_addr    (rs_addr),
        .rd_data    (rd_data),
        .rs_busy    (rs_busy),
        .rf_en      (rf_en),
        .rd         (rd),
        .write_data (write_data),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .flush      (flush),
        .busy_cnt   (busy_cnt)
`ifdef RF_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        rf_en      = 1'b0;
        rd         = '0;
        write_data = '0;
        issue_en   = 1'b0;
        issue_rd   = '0;
        flush      = 1'b0;
    endtask

    task automatic set_port(input int k, input int a);
        rs_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
        m_busy = '0;
        m_cnt  = 0;
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (rf_en && rd == AW'(a)) return write_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (rf_en && rd == AW'(a)) return 1'b0;
        return m_busy[a];
    endfunction

    // Advance the reference model with the current inputs, then one clock.
    task automatic step();
        logic [NREGS-1:0] nb;
        if (rst_n) begin
            if (rf_en && rd != 0) m_mem[rd] = write_data;
            if (flush) begin
                m_busy = '0;
                m_cnt  = 0;
            end else begin
                nb = m_busy;
                if (rf_en && m_busy[rd] && !(issue_en && issue_rd == rd)) begin
                    nb[rd] = 1'b0;
                    m_cnt--;
                end
                if (issue_en && issue_rd != 0 && !m_busy[issue_rd]) begin
                    nb[issue_rd] = 1'b1;
                    m_cnt++;
                end
                m_busy = nb;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rs_addr = '0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < NREGS; r++) begin
            set_port(0, r);
            set_port(1, r);
            #1;
            exp_q.push_back('0);
            exp_q.push_back('0);
            e = exp_q.pop_front(); checks++;
            if (rd_data[31:0] !== e) begin errors++; $display("FAIL reset_p0 x%0d: got %h exp %h", r, rd_data[31:0], e); end
            e = exp_q.pop_front(); checks++;
            if (rd_data[63:32] !== e) begin errors++; $display("FAIL reset_p1 x%0d: got %h exp %h", r, rd_data[63:32], e); end
            checks++;
            if (rs_busy !== 2'b00) begin errors++; $display("FAIL reset_busy x%0d: got %b exp 00", r, rs_busy); end
            checks++;
            if (busy_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", busy_cnt); end
            step();
        end
    endtask

    task automatic test_write();
        rf_en = 1'b1; rd = 5; write_data = 32'hDEADBEEF;
        set_port(0, 0); set_port(1, 0);
        step();
        idle();
        set_port(1, 5);
        #1;
        exp_q.push_back(32'hDEADBEEF);
        e = exp_q.pop_front(); checks++;
        if (rd_data[63:32] !== e) begin errors++; $display("FAIL write_x5: got %h exp %h", rd_data[63:32], e); end
        step();

        rf_en = 1'b1; rd = 0; write_data = 32'h1234;
        set_port(0, 0);
        #1;
        exp_q.push_back('0);
        e = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL write_x0_bypass: got %h exp %h", rd_data[31:0], e); end
        step();
        idle();
        #1;
        exp_q.push_back('0);
        e = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL write_x0: got %h exp %h", rd_data[31:0], e); end

        for (int r = 1; r < NREGS; r++) begin
            rf_en = 1'b1; rd = AW'(r); write_data = $urandom();
            step();
        end
        idle();
        for (int r = 0; r < NREGS; r++) begin
            set_port(0, r);
            set_port(1, NREGS - 1 - r);
            #1;
            exp_q.push_back(exp_data(r));
            exp_q.push_back(exp_data(NREGS - 1 - r));
            e = exp_q.pop_front(); checks++;
            if (rd_data[31:0] !== e) begin errors++; $display("FAIL fill_p0 x%0d: got %h exp %h", r, rd_data[31:0], e); end
            e = exp_q.pop_front(); checks++;
            if (rd_data[63:32] !== e) begin errors++; $display("FAIL fill_p1 x%0d: got %h exp %h", NREGS - 1 - r, rd_data[63:32], e); end
            step();
        end
    endtask

    task automatic test_bypass();
        rf_en = 1'b1; rd = 7; write_data = 32'hA5A5A5A5;
        set_port(0, 7); set_port(1, 8);
        #1;
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(exp_data(8));
        e = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL bypass_p0: got %h exp %h", rd_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (rd_data[63:32] !== e) begin errors++; $display("FAIL bypass_p1_x8: got %h exp %h", rd_data[63:32], e); end
        step();
        idle();
        #1;
        exp_q.push_back(32'hA5A5A5A5);
        e = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL bypass_stored_x7: got %h exp %h", rd_data[31:0], e); end
        step();
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_rd = 3;
        step();
        idle();
        set_port(0, 3);
        #1;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs_busy[0]} !== e) begin errors++; $display("FAIL issue_busy_x3: got %b exp %0d", rs_busy[0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL issue_cnt: got %0d exp %0d", busy_cnt, e); end

        rf_en = 1'b1; rd = 3; write_data = 32'h33;
        #1;
        exp_q.push_back(32'(exp_busy(3)));
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs_busy[0]} !== e) begin errors++; $display("FAIL wb_busy_x3: got %b exp %0d", rs_busy[0], e); end
        step();
        idle();
        #1;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL wb_cnt: got %0d exp %0d", busy_cnt, e); end

        issue_en = 1'b1; issue_rd = 3;
        step();
        issue_en = 1'b1; issue_rd = 3; rf_en = 1'b1; rd = 3; write_data = 32'h44;
        step();
        idle();
        #1;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h44);
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs_busy[0]} !== e) begin errors++; $display("FAIL same_cycle_busy_x3: got %b exp %0d", rs_busy[0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL same_cycle_cnt: got %0d exp %0d", busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL same_cycle_data_x3: got %h exp %h", rd_data[31:0], e); end

        issue_en = 1'b1; issue_rd = 3;
        step();
        idle();
        #1;
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL reissue_cnt: got %0d exp %0d", busy_cnt, e); end

        issue_en = 1'b1; issue_rd = 10; rf_en = 1'b1; rd = 3; write_data = 32'h55;
        step();
        idle();
        set_port(0, 10); set_port(1, 3);
        #1;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'b01);
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL set_clr_cnt: got %0d exp %0d", busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(rs_busy) !== e) begin errors++; $display("FAIL set_clr_busy: got %b exp %b", rs_busy, e[1:0]); end

        issue_en = 1'b1; issue_rd = 0;
        step();
        idle();
        set_port(0, 0);
        #1;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'(exp_busy(0)));
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL issue_x0_cnt: got %0d exp %0d", busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs_busy[0]} !== e) begin errors++; $display("FAIL issue_x0_busy: got %b exp %0d", rs_busy[0], e); end

        rf_en = 1'b1; rd = 11; write_data = 32'h1111;
        step();
        idle();
        set_port(0, 11); set_port(1, 10);
        #1;
        exp_q.push_back(32'b10);
        exp_q.push_back(32'(m_cnt));
        e = exp_q.pop_front(); checks++;
        if (32'(rs_busy) !== e) begin errors++; $display("FAIL nonbusy_write_busy: got %b exp %b", rs_busy, e[1:0]); end
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL nonbusy_write_cnt: got %0d exp %0d", busy_cnt, e); end
        step();
    endtask

    task automatic test_flush();
        issue_en = 1'b1; issue_rd = 1; step();
        issue_rd = 2; step();
        issue_rd = 4; step();
        idle();
        #1;
        exp_q.push_back(32'd4);
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL pre_flush_cnt: got %0d exp %0d", busy_cnt, e); end

        issue_en = 1'b1; issue_rd = 9; flush = 1'b1;
        rf_en = 1'b1; rd = 12; write_data = 32'hC0FFEE12;
        step();
        idle();
        set_port(0, 9); set_port(1, 12);
        #1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hC0FFEE12);
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL flush_cnt: got %0d exp %0d", busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(rs_busy) !== e) begin errors++; $display("FAIL flush_busy_x9_x12: got %b exp %b", rs_busy, e[1:0]); end
        e = exp_q.pop_front(); checks++;
        if (rd_data[63:32] !== e) begin errors++; $display("FAIL flush_write_x12: got %h exp %h", rd_data[63:32], e); end
        for (int r = 1; r < 5; r++) begin
            set_port(0, r);
            #1;
            exp_q.push_back(32'(exp_busy(r)));
            e = exp_q.pop_front(); checks++;
            if ({31'b0, rs_busy[0]} !== e) begin errors++; $display("FAIL flush_busy x%0d: got %b exp %0d", r, rs_busy[0], e); end
        end
        step();
    endtask

    task automatic test_async_reset();
        issue_en = 1'b1; issue_rd = 5; rf_en = 1'b1; rd = 13; write_data = 32'h1313;
        step();
        rf_en = 1'b0; issue_en = 1'b1; issue_rd = 6;
        set_port(0, 13); set_port(1, 5);
        #1;
        exp_q.push_back(32'h1313);
        e = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL pre_reset_x13: got %h exp %h", rd_data[31:0], e); end
        rst_n = 1'b0;
        model_reset();
        #1;
        exp_q.push_back('0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL async_reset_x13: got %h exp %h", rd_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(rs_busy) !== e) begin errors++; $display("FAIL async_reset_busy: got %b exp %b", rs_busy, e[1:0]); end
        e = exp_q.pop_front(); checks++;
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL async_reset_cnt: got %0d exp %0d", busy_cnt, e); end
        idle();
        #1;
        rst_n = 1'b1;
        step();
    endtask

`ifdef RF_PARITY_EN
    task automatic test_parity();
        rf_en = 1'b1; rd = 6; write_data = 32'h00000001;
        step();
        idle();
        set_port(0, 6); set_port(1, 7);
        #1;
        checks++;
        if (parity_err !== 2'b00) begin errors++; $display("FAIL parity_clean: got %b exp 00", parity_err); end
        dut.mem_par[6] = ~dut.mem_par[6];
        #1;
        checks++;
        if (parity_err !== 2'b01) begin errors++; $display("FAIL parity_flip: got %b exp 01", parity_err); end
        rf_en = 1'b1; rd = 6; write_data = 32'h00000002;
        #1;
        checks++;
        if (parity_err[0] !== 1'b0) begin errors++; $display("FAIL parity_bypass: got %b exp 0", parity_err[0]); end
        step();
        idle();
        #1;
        checks++;
        if (parity_err !== 2'b00) begin errors++; $display("FAIL parity_rewrite: got %b exp 00", parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_async_reset();
`ifdef RF_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
